// File: rtl/seq_shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for the shift-add multiplier.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-and-add multiplier: one partial product per clock, WIDTH iterations.
// state | meaning
// IDLE  | waiting for start; product holds last result
// RUN   | iterating, one add/shift per edge
// DONE  | one-cycle done pulse, product freshly updated
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic                c_q, c_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [WIDTH:0]      sum;

    // Full-width add keeps the carry-out; it becomes the accumulator MSB after the shift.
    always_comb begin
        if (q_q[0]) begin
            sum = {1'b0, a_q} + {1'b0, m_q} + {{WIDTH{1'b0}}, c_q};
        end else begin
            sum = {1'b0, a_q};
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d   = 1'b0;
                a_d   = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d  = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: directed vectors, a 4-bit sweep and a WIDTH=8 corner.
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.WIDTH(4)) bus ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_shift_add_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int pushed = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] m, input logic [3:0] q);
        logic [7:0] e;
        e = {4'b0, m} * {4'b0, q};
        exp_q.push_back(e);
        pushed++;
    endtask

    // Monitor: every done pulse consumes one expected product.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_seen++;
                check("done_single_cycle", {31'b0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %0d required no done", bus.product);
                end else begin
                    check("product", {24'b0, bus.product}, {24'b0, exp_q.pop_front()});
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic run_op(input logic [3:0] m, input logic [3:0] q);
        int busy_n;
        bit got;
        busy_n = 0;
        got = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        push_exp(m, q);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.multiplicand = ~m;
                bus.multiplier = ~q;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                check("latency", i, 5);
                check("busy_cycles", busy_n, 4);
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    initial begin
        bit got;
        int d1, d2;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus8.start = 1'b0;
        bus8.multiplicand = '0;
        bus8.multiplier = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 0);
        check("reset_done", {31'b0, bus.done}, 0);
        check("reset_product", {24'b0, bus.product}, 0);
        reset = 1'b0;

        run_op(4'd15, 4'd15);
        run_op(4'd9, 4'd6);
        repeat (3) @(negedge clk);
        check("product_hold", {24'b0, bus.product}, 54);
        run_op(4'd0, 4'd13);
        run_op(4'd13, 4'd0);

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd7;
        bus.multiplier = 4'd3;
        push_exp(4'd7, 4'd3);
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.multiplicand = 4'd15;
                bus.multiplier = 4'd15;
            end
            if (i == 2) begin
                bus.start = 1'b0;
                bus.multiplicand = 4'd2;
                bus.multiplier = 4'd2;
            end
            if (bus.done) begin
                got = 1;
                bus.start = 1'b1;
                bus.multiplicand = 4'd15;
                bus.multiplier = 4'd15;
                break;
            end
        end
        if (!got) check("ignore_timeout", 0, 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_after_done_start", {31'b0, bus.busy}, 0);
        repeat (8) @(negedge clk);
        check("product_after_ignore", {24'b0, bus.product}, 21);

        // reset on the third RUN cycle abandons the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd12;
        bus.multiplier = 4'd11;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 0);
        check("abort_done", {31'b0, bus.done}, 0);
        check("abort_product", {24'b0, bus.product}, 0);
        repeat (6) @(negedge clk);
        check("abort_stays_idle", {31'b0, bus.busy}, 0);
        run_op(4'd5, 4'd5);

        // start held high: back-to-back operations
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd3;
        bus.multiplier = 4'd4;
        push_exp(4'd3, 4'd4);
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.multiplicand = 4'd14;
                bus.multiplier = 4'd2;
                push_exp(4'd14, 4'd2);
            end
            if (i == 7) bus.start = 1'b0;
            if (i == 8) check("hold_between", {24'b0, bus.product}, 12);
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = i;
                end else begin
                    d2 = i;
                    break;
                end
            end
        end
        check("b2b_first_done", d1, 5);
        check("b2b_spacing", d2 - d1, 6);

        // WIDTH=8 corner
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.multiplicand = 8'd255;
        bus8.multiplier = 8'd255;
        got = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bus8.start = 1'b0;
            if (bus8.done) begin
                check("w8_latency", i, 9);
                check("w8_product", {16'b0, bus8.product}, 65025);
                got = 1;
                break;
            end
        end
        if (!got) check("w8_timeout", 0, 1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_seen, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
